apb_register_completer: RTL



---
 rtl/AXI_to_APB.sv | 17 +
 rtl/apb_register_completer_if.sv | 26 ++
 rtl/apb_wait_lfsr.sv | 31 +++
 rtl/apb_register_completer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/AXI_to_APB.sv
// Shared APB definitions: FSM state encoding, decode width and response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package AXI_to_APB;

    typedef enum logic [0:0] {
        APB_IDLE   = 1'b0,
        APB_ACCESS = 1'b1
    } apb_state_t;

    // Only the low byte-offset bits of paddr take part in register decode.
    localparam int APB_OFFSET_BITS = 12;

    localparam logic APB_RESP_OK  = 1'b0;
    localparam logic APB_RESP_ERR = 1'b1;

endpackage

// File: rtl/apb_register_completer_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
// Latency: n/a (wiring only).
// Backpressure: completer stretches the access phase by holding pready low.
interface apb_register_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [2:0]            psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_wait_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise completer wait states.
// Latency: advances every cycle; seed appears the cycle after reset.
// Backpressure: none. Compiled only with APB_COMPLETER_RANDWAIT_EN defined.
`ifdef APB_COMPLETER_RANDWAIT_EN
module apb_wait_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift left, feeding back the XOR of bits 16,14,13,11 (1-based).
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // State register; reseeds on reset so the wait sequence is repeatable.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;
endmodule
`endif

// File: rtl/apb_register_completer.sv
// APB completer serving NUM_REGS 32-bit registers (reg 0 = read-only ID) with pslverr.
// Latency: setup cycle + (WAIT_CYCLES+1) access cycles; random 0..15 waits with APB_COMPLETER_RANDWAIT_EN.
// Backpressure: pready held low during wait states; dropping psel/penable mid-access aborts.
module apb_register_completer
    import AXI_to_APB::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [2:0]            SLAVE_ID    = 3'd0,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA2B0_0001
) (
    input  logic                     clk,
    input  logic                     reset,
    apb_register_completer_if.slave  apb,
    output logic                     prot_violation
);
    localparam int IDX_W = APB_OFFSET_BITS - 2;

    apb_state_t                  state_q, state_d;
    logic [3:0]                  wait_cnt_q, wait_cnt_d;
    logic [APB_OFFSET_BITS-1:0]  paddr_q, paddr_d;
    logic                        pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]       pwdata_q, pwdata_d;
    logic                        prot_violation_q, prot_violation_d;
    logic [DATA_WIDTH-1:0]       regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0]       regs_d [1:NUM_REGS-1];

    logic                        sel;
    logic                        abort;
    logic                        complete;
    logic [IDX_W-1:0]            idx;
    logic                        err;
    logic                        do_write;
    logic [3:0]                  wait_load;
    logic [DATA_WIDTH-1:0]       rd_data;

    // Address bits above the decode window are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^apb.paddr[ADDR_WIDTH-1:APB_OFFSET_BITS];

`ifdef APB_COMPLETER_RANDWAIT_EN
    logic [15:0] lfsr_val;
    logic        unused_lfsr_hi;

    apb_wait_lfsr #(.SEED(16'hACE1)) u_wait_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_val)
    );

    assign unused_lfsr_hi = ^lfsr_val[15:4];
    assign wait_load      = lfsr_val[3:0];
`else
    assign wait_load = 4'(WAIT_CYCLES);
`endif

    assign sel      = (apb.psel == SLAVE_ID);
    assign abort    = (state_q == APB_ACCESS) && (!sel || !apb.penable);
    assign complete = (state_q == APB_ACCESS) && (wait_cnt_q == 4'd0);
    assign idx      = paddr_q[APB_OFFSET_BITS-1:2];
    assign do_write = complete && !abort && pwrite_q && !err;

    // Error decode from the latched request only.
    always_comb begin
        err = 1'b0;
        if (paddr_q[1:0] != 2'b00) begin
            err = 1'b1;
        end
        if ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS)) begin
            err = 1'b1;
        end
        if (pwrite_q && (idx == '0)) begin
            err = 1'b1;
        end
    end

    // Read mux: ID constant at index 0, register file elsewhere.
    always_comb begin
        rd_data = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (IDX_W'(i) == idx) begin
                rd_data = regs_q[i];
            end
        end
    end

    // Moore outputs: pready from state and counter; data/error gated by pready.
    always_comb begin
        apb.pready  = complete;
        apb.pslverr = (complete && err) ? APB_RESP_ERR : APB_RESP_OK;
        apb.prdata  = (complete && !err) ? rd_data : '0;
    end

    // Next-state logic: latch request at setup, count waits, complete or abort.
    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        paddr_d          = paddr_q;
        pwrite_d         = pwrite_q;
        pwdata_d         = pwdata_q;
        prot_violation_d = 1'b0;
        unique case (state_q)
            APB_IDLE: begin
                if (sel && !apb.penable) begin
                    paddr_d    = apb.paddr[APB_OFFSET_BITS-1:0];
                    pwrite_d   = apb.pwrite;
                    pwdata_d   = apb.pwdata;
                    wait_cnt_d = wait_load;
                    state_d    = APB_ACCESS;
                end
            end
            APB_ACCESS: begin
                if (abort) begin
                    prot_violation_d = 1'b1;
                    state_d          = APB_IDLE;
                end else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else begin
                    state_d = APB_IDLE;
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // Register file update: only a clean, error-free completing write lands.
    always_comb begin
        regs_d = regs_q;
        if (do_write) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (IDX_W'(i) == idx) begin
                    regs_d[i] = pwdata_q;
                end
            end
        end
    end

    // State registers; reset wins over any in-flight transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= APB_IDLE;
            wait_cnt_q       <= 4'd0;
            paddr_q          <= '0;
            pwrite_q         <= 1'b0;
            pwdata_q         <= '0;
            prot_violation_q <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            wait_cnt_q       <= wait_cnt_d;
            paddr_q          <= paddr_d;
            pwrite_q         <= pwrite_d;
            pwdata_q         <= pwdata_d;
            prot_violation_q <= prot_violation_d;
            regs_q           <= regs_d;
        end
    end

    assign prot_violation = prot_violation_q;
endmodule
